// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the CPU MEM/WB slice.
//   - XLEN / REG_AW : datapath and register-address widths
//   - mem_state_e   : state encoding for the data-memory access FSM
//   - word_addr()   : drops the byte offset of a byte address
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    function automatic logic [XLEN-3:0] word_addr(input logic [XLEN-1:0] byte_addr);
        return byte_addr[XLEN-1:2];
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
//   Data-memory request/acknowledge bus between the MEM stage and memory.
//   Signals (stage-side names in brackets):
//     req   [dmem_req_o]   access request, held until ack or abort
//     we    [dmem_we_o]    1 = write
//     addr  [dmem_addr_o]  word address, bits [1:0] always 0
//     wdata [dmem_wdata_o] store data
//     ack   [dmem_ack_i]   single-cycle completion pulse
//     rdata [dmem_rdata_i] load data, valid with ack
//   Modports: master (MEM stage), slave (memory).
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;
    import cpu_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_wb_stage_dmem_access_fsm.sv
// ---------------------------------------------------------------------------
// dmem_access_fsm
//   Issues one data-memory access per load/store, holds the request until the
//   acknowledge arrives or the timeout counter expires, and tells the stage
//   when to stall and when the instruction in MEM may commit.
//   Optional feature macro: MEMWB_ALIGN_CHECK_EN (adds misaligned_i/misalign_o).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no access outstanding; memops are issued from here
//   ACCESS | request on the bus, waiting for ack or timeout
//
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     memop_i           instruction in MEM is a load or store
//     we_i              access is a write
//     addr_i            word address (byte offset already removed)
//     wdata_i           store data
//     misaligned_i      (macro only) byte offset of the address is non-zero
//     dmem              memory bus, master side
//     stall_o           hold upstream stages (combinational)
//     commit_o          MEM/WB loads the instruction this cycle
//     ack_commit_o      commit is the completion of a memory access
//     err_o             one-cycle pulse after an access timeout
//     misalign_o        (macro only) one-cycle pulse after a rejected memop
// ---------------------------------------------------------------------------
module dmem_access_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memop_i,
    input  logic              we_i,
    input  logic [XLEN-3:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
`ifdef MEMWB_ALIGN_CHECK_EN
    input  logic              misaligned_i,
    output logic              misalign_o,
`endif
    mem_wb_stage_if.master    dmem,
    output logic              stall_o,
    output logic              commit_o,
    output logic              ack_commit_o,
    output logic              err_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e      r_state;
    mem_state_e      w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-3:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_we;
    logic            r_err;
    logic            w_stall;
    logic            w_issue;
    logic            w_timeout;
    logic            w_tc;
    logic            w_reject;
`ifdef MEMWB_ALIGN_CHECK_EN
    logic            r_misalign;
`endif

    // Terminal count: last ACCESS cycle allowed without an ack.
    assign w_tc = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef MEMWB_ALIGN_CHECK_EN
    assign w_reject = misaligned_i;
`else
    assign w_reject = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_stall      = 1'b0;
        commit_o     = 1'b0;
        ack_commit_o = 1'b0;
        w_issue      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!memop_i) begin
                    commit_o = 1'b1;
                end else if (!w_reject) begin
                    w_stall = 1'b1;
                    w_issue = 1'b1;
                    w_next  = ST_ACCESS;
                end
                // rejected memop: no stall, no commit -> bubble
            end
            ST_ACCESS: begin
                // ack on the terminal-count cycle still completes the access
                if (dmem.ack) begin
                    commit_o     = 1'b1;
                    ack_commit_o = 1'b1;
                    w_next       = ST_IDLE;
                end else if (w_tc) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_timeout;
            if (w_issue) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_we    <= we_i;
            end
            if (r_state == ST_ACCESS && w_next == ST_ACCESS)
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
        end
    end

`ifdef MEMWB_ALIGN_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_misalign <= 1'b0;
        else
            r_misalign <= (r_state == ST_IDLE) && memop_i && misaligned_i;
    end
    assign misalign_o = r_misalign;
`endif

    assign dmem.req   = (r_state == ST_ACCESS);
    assign dmem.we    = r_we;
    assign dmem.addr  = {r_addr, 2'b00};
    assign dmem.wdata = r_wdata;

    // The stall is held low while reset is asserted so all outputs read 0.
    assign stall_o = w_stall & ~rst_i;
    assign err_o   = r_err;

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM stage and MEM/WB pipeline register. Loads/stores go through the
//   dmem_access_fsm sub-module; this level selects the write-back data and
//   holds the MEM/WB register. Cycles that do not commit load a bubble
//   (all MEM/WB fields 0).
//   Optional feature macro: MEMWB_ALIGN_CHECK_EN (misaligned memops rejected,
//   misalign_o pulses); undefined, the address byte offset is dropped.
//
//   Ports:
//     clk_i, rst_i                  clock, synchronous active-high reset
//     pc_i, ALUres_i, wrdata_i      EX/MEM fields
//     rd_addr_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i
//     dmem                          data-memory bus (master)
//     stall_o                       combinational stall to the hazard unit
//     err_o                         access-timeout pulse
//     misalign_o                    (macro only) misaligned-access pulse
//     pc_o, wbdata_o, rd_addr_o, RegWrite_o   MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   ALUres_i,
    input  logic [XLEN-1:0]   wrdata_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    mem_wb_stage_if.master    dmem,
    output logic              stall_o,
    output logic              err_o,
`ifdef MEMWB_ALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   wbdata_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              RegWrite_o
);

    logic              w_memop;
    logic              w_commit;
    logic              w_ack_commit;
    logic              w_use_rdata;
    logic [XLEN-1:0]   w_wbdata;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_wbdata;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;

    assign w_memop = MemRead_i | MemWrite_i;

    dmem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .memop_i      (w_memop),
        .we_i         (MemWrite_i),
        .addr_i       (word_addr(ALUres_i)),
        .wdata_i      (wrdata_i),
`ifdef MEMWB_ALIGN_CHECK_EN
        .misaligned_i (ALUres_i[1:0] != 2'b00),
        .misalign_o   (misalign_o),
`endif
        .dmem         (dmem),
        .stall_o      (stall_o),
        .commit_o     (w_commit),
        .ack_commit_o (w_ack_commit),
        .err_o        (err_o)
    );

    // Load data only on a completed read; load+store behaves as a store.
    assign w_use_rdata = w_ack_commit & MemtoReg_i & ~MemWrite_i;
    assign w_wbdata    = w_use_rdata ? dmem.rdata : ALUres_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || !w_commit) begin
            r_pc       <= '0;
            r_wbdata   <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
        end else begin
            r_pc       <= pc_i;
            r_wbdata   <= w_wbdata;
            r_rd       <= rd_addr_i;
            r_regwrite <= RegWrite_i;
        end
    end

    assign pc_o       = r_pc;
    assign wbdata_o   = r_wbdata;
    assign rd_addr_o  = r_rd;
    assign RegWrite_o = r_regwrite;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage (TIMEOUT_CYCLES = 4). Each instruction is
//   described by its fields plus the number of ACCESS cycles the memory waits
//   before acknowledging; the bench derives from that the expected stall,
//   request and MEM/WB timeline per cycle, and a compare process checks the
//   DUT against it on every negative clock edge.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam int TMO = 4;
    localparam int NC  = 1024;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [XLEN-1:0]   pc_i, ALUres_i, wrdata_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
    logic              stall_o, err_o, RegWrite_o;
    logic [XLEN-1:0]   pc_o, wbdata_o;
    logic [REG_AW-1:0] rd_addr_o;
`ifdef MEMWB_ALIGN_CHECK_EN
    logic              misalign_o;
`endif

    mem_wb_stage_if dmem_bus();

    mem_wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .pc_i       (pc_i),
        .ALUres_i   (ALUres_i),
        .wrdata_i   (wrdata_i),
        .rd_addr_i  (rd_addr_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .RegWrite_i (RegWrite_i),
        .MemtoReg_i (MemtoReg_i),
        .dmem       (dmem_bus),
        .stall_o    (stall_o),
        .err_o      (err_o),
`ifdef MEMWB_ALIGN_CHECK_EN
        .misalign_o (misalign_o),
`endif
        .pc_o       (pc_o),
        .wbdata_o   (wbdata_o),
        .rd_addr_o  (rd_addr_o),
        .RegWrite_o (RegWrite_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_stall_seen = 0;
    int n_req_seen   = 0;
    int n_beef_seen  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // expected timeline, indexed by cycle number
    bit              e_v     [NC];
    bit              e_stall [NC];
    bit              e_req   [NC];
    bit              e_we    [NC];
    logic [XLEN-1:0] e_addr  [NC];
    logic [XLEN-1:0] e_wdata [NC];
    bit              e_ov    [NC];
    bit              e_cm    [NC];
    bit              e_regw  [NC];
    bit              e_err   [NC];
    logic [XLEN-1:0] e_wb    [NC];
    logic [XLEN-1:0] e_pc    [NC];
    logic [REG_AW-1:0] e_rd  [NC];
`ifdef MEMWB_ALIGN_CHECK_EN
    bit              e_mis   [NC];
`endif

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stall_o) n_stall_seen++;
        if (dmem_bus.req) n_req_seen++;
        if (RegWrite_o && wbdata_o == 32'hDEADBEEF) n_beef_seen++;
        if (cyc < NC) begin
            if (e_v[cyc]) begin
                chk("stall", cyc, 32'(stall_o), 32'(e_stall[cyc]));
                chk("req",   cyc, 32'(dmem_bus.req), 32'(e_req[cyc]));
                if (e_req[cyc]) begin
                    chk("we",    cyc, 32'(dmem_bus.we), 32'(e_we[cyc]));
                    chk("addr",  cyc, dmem_bus.addr, e_addr[cyc]);
                    chk("wdata", cyc, dmem_bus.wdata, e_wdata[cyc]);
                end
            end
            if (e_ov[cyc]) begin
                chk("regwrite", cyc, 32'(RegWrite_o), 32'(e_regw[cyc]));
                chk("err",      cyc, 32'(err_o), 32'(e_err[cyc]));
`ifdef MEMWB_ALIGN_CHECK_EN
                chk("misalign", cyc, 32'(misalign_o), 32'(e_mis[cyc]));
`endif
                if (e_cm[cyc]) begin
                    chk("wbdata", cyc, wbdata_o, e_wb[cyc]);
                    chk("pc",     cyc, pc_o, e_pc[cyc]);
                    chk("rd",     cyc, 32'(rd_addr_o), 32'(e_rd[cyc]));
                end
            end
        end
    end

    // Presents one instruction and records what the stage must do with it.
    // dly = ACCESS cycles before ack; dly >= TMO means memory never answers.
    task automatic run_instr(input bit mr, input bit mw, input bit rw, input bit m2r,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [31:0] pc, input logic [4:0] rd,
                             input int dly, input logic [31:0] rdat);
        bit memop, mis, acks, last, commit;
        int len, c;
        memop = mr | mw;
        mis   = 1'b0;
`ifdef MEMWB_ALIGN_CHECK_EN
        mis   = memop && (alu[1:0] != 2'b00);
`endif
        acks  = memop && !mis && (dly < TMO);
        if (!memop || mis) len = 1;
        else if (acks)     len = dly + 2;
        else               len = TMO + 1;
        MemRead_i = mr; MemWrite_i = mw; RegWrite_i = rw; MemtoReg_i = m2r;
        ALUres_i = alu; wrdata_i = wd; pc_i = pc; rd_addr_i = rd;
        for (int k = 0; k < len; k++) begin
            c    = cyc;
            last = (k == len - 1);
            dmem_bus.ack   = acks && last;
            dmem_bus.rdata = (acks && last) ? rdat : 32'h0BADF00D;
            e_v[c]     = 1'b1;
            e_stall[c] = !last;
            e_req[c]   = memop && !mis && (k > 0);
            e_we[c]    = mw;
            e_addr[c]  = {alu[31:2], 2'b00};
            e_wdata[c] = wd;
            commit     = last && (!memop || acks);
            e_ov[c+1]   = 1'b1;
            e_cm[c+1]   = commit;
            e_regw[c+1] = commit && rw;
            e_wb[c+1]   = (acks && m2r && !mw) ? rdat : alu;
            e_pc[c+1]   = pc;
            e_rd[c+1]   = rd;
            e_err[c+1]  = last && memop && !mis && !acks;
`ifdef MEMWB_ALIGN_CHECK_EN
            e_mis[c+1]  = last && mis;
`endif
            @(posedge clk); #1;
        end
        dmem_bus.ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        int s0, r0;
        rst_i = 1'b1;
        MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
        ALUres_i = 0; wrdata_i = 0; pc_i = 0; rd_addr_i = 0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_regwrite", cyc, 32'(RegWrite_o), 32'h0);
        chk("reset_wbdata",   cyc, wbdata_o, 32'h0);
        chk("reset_pc",       cyc, pc_o, 32'h0);
        chk("reset_req",      cyc, 32'(dmem_bus.req), 32'h0);
        chk("reset_err",      cyc, 32'(err_o), 32'h0);
        chk("reset_stall",    cyc, 32'(stall_o), 32'h0);
        rst_i = 1'b0;

        // ALU op
        run_instr(0, 0, 1, 0, 32'h1234, 32'h0, 32'h10, 5'd5, 0, 32'h0);
        chk("lit_alu_wb",   cyc, wbdata_o, 32'h1234);
        chk("lit_alu_regw", cyc, 32'(RegWrite_o), 32'h1);

        // load, ack after 3 waiting ACCESS cycles (ack on the terminal cycle)
        s0 = n_stall_seen;
        run_instr(1, 0, 1, 1, 32'h100, 32'h0, 32'h14, 5'd7, 3, 32'hDEADBEEF);
        chk("lit_load_stalls", cyc, 32'(n_stall_seen - s0), 32'd4);
        chk("lit_load_wb",     cyc, wbdata_o, 32'hDEADBEEF);

        // store
        r0 = n_req_seen;
        run_instr(0, 1, 0, 0, 32'h40, 32'hA5A5A5A5, 32'h18, 5'd0, 2, 32'h12345678);
        chk("lit_store_req_cycles", cyc, 32'(n_req_seen - r0), 32'd3);
        chk("lit_store_regw",       cyc, 32'(RegWrite_o), 32'h0);
        chk("lit_beef_commits",     cyc, 32'(n_beef_seen), 32'd1);

        // load with no ack -> timeout
        s0 = n_stall_seen; r0 = n_req_seen;
        run_instr(1, 0, 1, 1, 32'h200, 32'h0, 32'h1C, 5'd9, 99, 32'h0);
        chk("lit_tmo_stalls",   cyc, 32'(n_stall_seen - s0), 32'd4);
        chk("lit_tmo_req",      cyc, 32'(n_req_seen - r0), 32'd4);
        chk("lit_tmo_err",      cyc, 32'(err_o), 32'h1);
        chk("lit_tmo_regw",     cyc, 32'(RegWrite_o), 32'h0);

        // minimum-occupancy load, load+store, offset address, back-to-back ALU
        run_instr(1, 0, 1, 1, 32'h304, 32'h0, 32'h20, 5'd11, 0, 32'hCAFEF00D);
        run_instr(1, 1, 1, 1, 32'h88, 32'h5A5A0000, 32'h24, 5'd12, 1, 32'h77777777);
        run_instr(1, 0, 1, 1, 32'h102, 32'h0, 32'h28, 5'd13, 1, 32'h13572468);
`ifdef MEMWB_ALIGN_CHECK_EN
        chk("lit_misalign", cyc, 32'(misalign_o), 32'h1);
`endif
        run_instr(0, 0, 1, 0, 32'hFFFF0001, 32'h0, 32'h2C, 5'd14, 0, 32'h0);
        run_instr(0, 0, 0, 0, 32'h00000055, 32'h0, 32'h30, 5'd15, 0, 32'h0);

        // reset in the middle of an access, then a late ack while IDLE
        MemRead_i = 1; MemWrite_i = 0; RegWrite_i = 1; MemtoReg_i = 1;
        ALUres_i = 32'h500; pc_i = 32'h34; rd_addr_i = 5'd16;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_req",  cyc, 32'(dmem_bus.req), 32'h0);
        chk("rst_mid_regw", cyc, 32'(RegWrite_o), 32'h0);
        chk("rst_mid_wb",   cyc, wbdata_o, 32'h0);
        chk("rst_mid_err",  cyc, 32'(err_o), 32'h0);
        rst_i = 1'b0;
        MemRead_i = 0; RegWrite_i = 1; MemtoReg_i = 0;
        ALUres_i = 32'h77; pc_i = 32'h200; rd_addr_i = 5'd3;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("late_ack_stall", cyc, 32'(stall_o), 32'h0);
        chk("late_ack_req",   cyc, 32'(dmem_bus.req), 32'h0);
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        chk("late_ack_wb",   cyc, wbdata_o, 32'h77);
        chk("late_ack_regw", cyc, 32'(RegWrite_o), 32'h1);
        chk("late_ack_req2", cyc, 32'(dmem_bus.req), 32'h0);

        run_instr(1, 0, 1, 1, 32'h600, 32'h0, 32'h204, 5'd4, 2, 32'h0F0F0F0F);
        run_instr(0, 0, 1, 0, 32'h99, 32'h0, 32'h208, 5'd6, 0, 32'h0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
